mebx_pio_in_irq: RTL and testbench

Parametrised Avalon-MM input PIO: the successor to the fixed 8-bit DIP-switch input port, generalised in width and extended with a two-flop synchroniser, edge capture, a per-bit interrupt mask and an optional debounce filter. It sits on the Qsys/Platform Designer bus as a 4-word slave for the Nios II. It serves DIP switches, push buttons and slow status lines from the board or the FEE link logic. Readdata is registered and zero-extended to 32 bits, giving one-cycle read latency.

---
 rtl/mebx_pio_pkg.sv | 19 +
 rtl/mebx_pio_debounce_bit.sv | 45 ++++
 rtl/mebx_pio_in_irq.sv | 115 +++++++++++
 tb/tb_mebx_pio_in_irq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mebx_pio_pkg.sv
// Shared constants and types for the mebx input PIO.
// MEBX_PIO_DEBOUNCE_EN selects the debounce build.
package mebx_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_e;

  function automatic int dbc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mebx_pio_debounce_bit.sv
// One debounce lane: a stability counter and the filtered output flop.
// Built only when MEBX_PIO_DEBOUNCE_EN is defined.
module mebx_pio_debounce_bit
  import mebx_pio_pkg::*;
#(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic cond
);

  localparam int CW = dbc_width(CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          cond_q, cond_d;

  // Any return of din to cond ends the glitch and restarts the count.
  always_comb begin
    cnt_d  = '0;
    cond_d = cond_q;
    if (din != cond_q) begin
      if (cnt_q == CMAX) begin
        cond_d = din;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      cond_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cond_q <= cond_d;
    end
  end

  assign cond = cond_q;

endmodule

// File: rtl/mebx_pio_in_irq.sv
// Avalon-MM input PIO with sync, edge capture, irq mask.
// Optional debounce filter under MEBX_PIO_DEBOUNCE_EN.
module mebx_pio_in_irq
  import mebx_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam edge_e ET = edge_e'(EDGE_TYPE[1:0]);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [1:0]       arm_q, arm_d;

  logic [WIDTH-1:0] cond;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;
  logic             armed;
  logic             unused_wd;

`ifdef MEBX_PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    mebx_pio_debounce_bit #(
      .CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sync2_q[i]),
      .cond    (cond[i])
    );
  end
`else
  assign cond = sync2_q;
`endif

  assign wr_en     = !write_n;
  assign wdata     = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  // Capture stays off until prev has caught up with the synchroniser.
  assign armed     = (arm_q == 2'd3);

  always_comb begin
    edge_det = '0;
    case (ET)
      EDGE_RISE: edge_det = cond & ~prev_q;
      EDGE_FALL: edge_det = ~cond & prev_q;
      default:   edge_det = cond ^ prev_q;
    endcase
  end

  always_comb begin
    sync1_d   = in_port;
    sync2_d   = sync1_q;
    prev_d    = cond;
    arm_d     = armed ? arm_q : arm_q + 2'd1;
    mask_d    = mask_q;
    clr       = '0;
    if (wr_en && address == ADDR_IRQMASK) mask_d = wdata;
    if (wr_en && address == ADDR_EDGECAP) clr = wdata;
    // A same-cycle edge overrides its own clear.
    edgecap_d = edgecap_q & ~clr;
    if (armed) edgecap_d = edgecap_d | edge_det;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = cond;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      mask_q     <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      arm_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      arm_q      <= arm_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & mask_q);

endmodule

// File: tb/tb_mebx_pio_in_irq.sv
// Directed vector bench for mebx_pio_in_irq (8-bit rising and
// 32-bit any-edge instances on a shared bus).
module tb_mebx_pio_in_irq;

`ifdef MEBX_PIO_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd8, rd32;
  logic [7:0]  in8;
  logic [31:0] in32;
  logic        irq8, irq32;

  int n_cmp = 0;
  int n_err = 0;

  mebx_pio_in_irq #(
    .WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .write_n(write_n), .writedata(writedata),
    .readdata(rd8), .in_port(in8), .irq(irq8)
  );

  mebx_pio_in_irq #(
    .WIDTH(32), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)
  ) dut32 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .write_n(write_n), .writedata(writedata),
    .readdata(rd32), .in_port(in32), .irq(irq32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  inp;
    logic        wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    int          cyc;
    bit          chg;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    @(negedge clk);
    write_n   = 1'b1;
  endtask

  initial begin
    tv[0]  = '{8'hA5, 1'b1, 2'd1, 32'h01, 2'd1, 1, 1'b0, 32'h01, 1'b0};
    tv[1]  = '{8'hA4, 1'b0, 2'd0, 32'h00, 2'd2, 3, 1'b1, 32'h00, 1'b0};
    tv[2]  = '{8'hA5, 1'b0, 2'd0, 32'h00, 2'd2, 3, 1'b1, 32'h01, 1'b1};
    tv[3]  = '{8'hA5, 1'b0, 2'd0, 32'h00, 2'd0, 1, 1'b0, 32'hA5, 1'b1};
    tv[4]  = '{8'hA5, 1'b1, 2'd2, 32'h01, 2'd2, 1, 1'b0, 32'h00, 1'b0};
    tv[5]  = '{8'h25, 1'b0, 2'd0, 32'h00, 2'd2, 3, 1'b1, 32'h00, 1'b0};
    tv[6]  = '{8'hE5, 1'b0, 2'd0, 32'h00, 2'd2, 3, 1'b1, 32'hC0, 1'b0};
    tv[7]  = '{8'hE5, 1'b1, 2'd1, 32'hFF, 2'd1, 1, 1'b0, 32'hFF, 1'b1};
    tv[8]  = '{8'hE5, 1'b1, 2'd2, 32'h40, 2'd2, 1, 1'b0, 32'h80, 1'b1};
    tv[9]  = '{8'hE5, 1'b1, 2'd2, 32'h80, 2'd2, 1, 1'b0, 32'h00, 1'b0};
    tv[10] = '{8'hE5, 1'b1, 2'd0, 32'h00, 2'd0, 1, 1'b0, 32'hE5, 1'b0};
    tv[11] = '{8'hE5, 1'b1, 2'd3, 32'hFF, 2'd3, 1, 1'b0, 32'h00, 1'b0};
    tv[12] = '{8'hE5, 1'b1, 2'd1, 32'h00, 2'd1, 1, 1'b0, 32'h00, 1'b0};

    reset_n   = 1'b0;
    address   = 2'd0;
    write_n   = 1'b1;
    writedata = '0;
    in8       = 8'hA5;
    in32      = '0;

    // Reset state and power-up with inputs already high
    repeat (3) @(negedge clk);
    chk("rst_rd8", rd8, 32'h0);
    chk("rst_irq8", {31'b0, irq8}, 32'h0);
    chk("rst_rd32", rd32, 32'h0);
    chk("rst_irq32", {31'b0, irq32}, 32'h0);
    reset_n = 1'b1;
    repeat (4 + DB) @(negedge clk);
    chk("pwr_data", rd8, 32'hA5);
    address = 2'd2;
    @(negedge clk);
    chk("pwr_edgecap", rd8, (DB > 0) ? 32'hA5 : 32'h0);
    chk("pwr_irq", {31'b0, irq8}, 32'h0);
    bus_write(2'd2, 32'hFF);

    for (int i = 0; i < 13; i++) begin
      in8 = tv[i].inp;
      if (tv[i].wr) begin
        address   = tv[i].waddr;
        writedata = tv[i].wdata;
        write_n   = 1'b0;
      end
      @(negedge clk);
      write_n = 1'b1;
      address = tv[i].raddr;
      repeat (tv[i].cyc + (tv[i].chg ? DB : 0)) @(negedge clk);
      chk($sformatf("vec%0d_rd", i), rd8, tv[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'b0, irq8}, {31'b0, tv[i].exp_irq});
    end

    // Clear and new edge on the same cycle: edge wins
    bus_write(2'd1, 32'h01);
    in8 = 8'hE4;
    repeat (4 + DB) @(negedge clk);
    in8 = 8'hE5;
    repeat (2 + DB) @(negedge clk);
    address   = 2'd2;
    writedata = 32'h01;
    write_n   = 1'b0;
    @(negedge clk);
    write_n = 1'b1;
    chk("race_irq", {31'b0, irq8}, 32'h1);
    @(negedge clk);
    chk("race_edgecap", rd8, 32'h01);
    bus_write(2'd2, 32'h01);
    chk("clr_irq", {31'b0, irq8}, 32'h0);
    address = 2'd2;
    @(negedge clk);
    chk("clr_edgecap", rd8, 32'h0);

`ifdef MEBX_PIO_DEBOUNCE_EN
    // Short glitch is filtered, stable level passes after DB cycles
    in8 = 8'hE7;
    repeat (10) @(negedge clk);
    in8 = 8'hE5;
    address = 2'd0;
    repeat (30) @(negedge clk);
    chk("db_glitch_data", rd8, 32'hE5);
    address = 2'd2;
    @(negedge clk);
    chk("db_glitch_edgecap", rd8, 32'h0);
    address = 2'd0;
    in8 = 8'hE7;
    repeat (18) @(negedge clk);
    chk("db_early_data", rd8, 32'hE5);
    @(negedge clk);
    chk("db_late_data", rd8, 32'hE7);
    address = 2'd2;
    @(negedge clk);
    chk("db_edgecap", rd8, 32'h02);
    bus_write(2'd2, 32'h02);
`endif

    // 32-bit any-edge instance: falling edge on bit31
    in32 = 32'h8000_0000;
    repeat (4 + DB) @(negedge clk);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'h8000_0000);
    chk("w32_irq_idle", {31'b0, irq32}, 32'h0);
    in32 = 32'h0;
    address = 2'd2;
    repeat (4 + DB) @(negedge clk);
    chk("w32_edgecap", rd32, 32'h8000_0000);
    chk("w32_irq", {31'b0, irq32}, 32'h1);
    bus_write(2'd3, 32'hFFFF_FFFF);
    address = 2'd3;
    @(negedge clk);
    chk("w32_rsvd", rd32, 32'h0);
    address = 2'd2;
    @(negedge clk);
    chk("w32_edgecap_kept", rd32, 32'h8000_0000);
    address = 2'd1;
    @(negedge clk);
    chk("w32_mask_kept", rd32, 32'h8000_0000);
    chk("w32_irq_kept", {31'b0, irq32}, 32'h1);

    // Mid-operation reset with everything pending
    in8 = 8'h00;
    repeat (4 + DB) @(negedge clk);
    bus_write(2'd2, 32'hFF);
    bus_write(2'd1, 32'hFF);
    in8 = 8'hFF;
    address = 2'd2;
    repeat (4 + DB) @(negedge clk);
    chk("pre_rst_edgecap", rd8, 32'hFF);
    chk("pre_rst_irq", {31'b0, irq8}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_irq8", {31'b0, irq8}, 32'h0);
    chk("async_rst_rd8", rd8, 32'h0);
    chk("async_rst_irq32", {31'b0, irq32}, 32'h0);
    chk("async_rst_rd32", rd32, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    address = 2'd2;
    repeat (5) @(negedge clk);
    chk("post_rst_edgecap", rd8, 32'h0);
    address = 2'd1;
    @(negedge clk);
    chk("post_rst_mask", rd8, 32'h0);
    chk("post_rst_irq", {31'b0, irq8}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
